// File: rtl/sdm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdm_pkg
// Description : Shared constants for the sigma-delta modulator. DEFAULT_OSR is
//               the same ratio the decimating Filter uses, so both ends of a
//               loopback agree on the frame length.
// Revision    : 1.0 - initial release
// ============================================================================
package sdm_pkg;

  localparam int SAMPLE_W = 8;
  localparam logic [SAMPLE_W-1:0] MIDSCALE = 8'h80;
  localparam int DEFAULT_OSR = 256;

endpackage : sdm_pkg
`default_nettype wire

// File: rtl/sigma_delta_modulator_if.sv
`default_nettype none
// ============================================================================
// Module      : sigma_delta_modulator_if
// Description : PCM sample handshake plus bitstream/status outputs of the
//               sigma-delta modulator. master = sample source, slave = DUT.
//               Build option: SDM_MUTE_EN adds the MUTE control signal.
// Revision    : 1.0 - initial release
// ============================================================================
interface sigma_delta_modulator_if;
  import sdm_pkg::*;

  logic [SAMPLE_W-1:0] IN;
  logic                IN_VALID;
  logic                IN_READY;
  logic                OUT;
  logic                FRAME;
  logic                UNDERRUN;
`ifdef SDM_MUTE_EN
  logic                MUTE;
`endif

  modport master (
`ifdef SDM_MUTE_EN
    output MUTE,
`endif
    output IN, IN_VALID,
    input  IN_READY, OUT, FRAME, UNDERRUN
  );

  modport slave (
`ifdef SDM_MUTE_EN
    input  MUTE,
`endif
    input  IN, IN_VALID,
    output IN_READY, OUT, FRAME, UNDERRUN
  );

endinterface : sigma_delta_modulator_if
`default_nettype wire

// File: rtl/sdm_accum.sv
`default_nettype none
// ============================================================================
// Module      : sdm_accum
// Description : First-order accumulator modulator. The carry out of the 8-bit
//               phase accumulator is the pulse-density output bit, so over 256
//               cycles at a constant sample the number of ones equals the
//               sample exactly.
// Revision    : 1.0 - initial release
// ============================================================================
module sdm_accum
  import sdm_pkg::*;
(
  input  wire logic                CLK,
  input  wire logic                RST,
  input  wire logic [SAMPLE_W-1:0] sample_i,
  output logic                     bit_o
);

  logic [SAMPLE_W-1:0] acc_q;
  logic [SAMPLE_W-1:0] acc_d;
  logic                out_q;
  logic                out_d;
  logic [SAMPLE_W:0]   sum;

  // Adder: the carry bit becomes the next output bit, the residue the new phase.
  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, sample_i};
    acc_d = sum[SAMPLE_W-1:0];
    out_d = sum[SAMPLE_W];
  end

  // Phase accumulator and output register; acc is never cleared between frames.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      acc_q <= '0;
      out_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      out_q <= out_d;
    end
  end

  assign bit_o = out_q;

endmodule : sdm_accum
`default_nettype wire

// File: rtl/sigma_delta_modulator.sv
`default_nettype none
// ============================================================================
// Module      : sigma_delta_modulator
// Description : Accepts 8-bit unsigned PCM over valid/ready, holds each sample
//               for OSR clocks and emits a 1-bit pulse-density stream.
//               Build option: SDM_MUTE_EN - MUTE forces midscale into the
//               modulator (50% density) without disturbing the handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module sigma_delta_modulator
  import sdm_pkg::*;
#(
  parameter int OSR = DEFAULT_OSR,
  parameter int CW  = 16
) (
  input  wire logic              CLK,
  input  wire logic              RST,
  sigma_delta_modulator_if.slave sdm
);

  logic [SAMPLE_W-1:0] hold_q, hold_d;
  logic                hold_valid_q, hold_valid_d;
  logic [SAMPLE_W-1:0] cur_q, cur_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                frame_q, frame_d;
  logic                underrun_q, underrun_d;
  logic                boundary;
  logic                accept;
  logic [SAMPLE_W-1:0] mod_in;
  logic                out_bit;

  assign boundary = (cnt_q == CW'(OSR - 1));
  // Hold is only writable when empty, so an accept never coincides with a
  // boundary that is draining a full hold register.
  assign accept   = sdm.IN_VALID && !hold_valid_q;

  // Next-state: frame counter, hold/cur hand-over at boundaries, underrun flag.
  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    cur_d        = cur_q;
    underrun_d   = underrun_q;
    frame_d      = boundary;
    cnt_d        = boundary ? '0 : cnt_q + CW'(1);

    if (boundary) begin
      if (hold_valid_q) begin
        cur_d        = hold_q;
        hold_valid_d = 1'b0;
      end else begin
        // Empty at the boundary: repeat cur; a same-cycle accept is not bypassed.
        underrun_d   = 1'b1;
      end
    end

    if (accept) begin
      hold_d       = sdm.IN;
      hold_valid_d = 1'b1;
    end
  end

  // State registers; reset discards any held sample and partial frame.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      cur_q        <= '0;
      cnt_q        <= '0;
      frame_q      <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      cur_q        <= cur_d;
      cnt_q        <= cnt_d;
      frame_q      <= frame_d;
      underrun_q   <= underrun_d;
    end
  end

`ifdef SDM_MUTE_EN
  assign mod_in = sdm.MUTE ? MIDSCALE : cur_q;
`else
  assign mod_in = cur_q;
`endif

  sdm_accum u_accum (
    .CLK      (CLK),
    .RST      (RST),
    .sample_i (mod_in),
    .bit_o    (out_bit)
  );

  assign sdm.IN_READY = !hold_valid_q;
  assign sdm.OUT      = out_bit;
  assign sdm.FRAME    = frame_q;
  assign sdm.UNDERRUN = underrun_q;

endmodule : sigma_delta_modulator
`default_nettype wire

// File: tb/tb_sigma_delta_modulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_sigma_delta_modulator
// Description : Directed self-checking bench for sigma_delta_modulator.
//               With SDM_MUTE_EN defined the mute scenario is also exercised.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sigma_delta_modulator;

  localparam int OSR = 256;

  logic CLK;
  logic RST;
  int   n_vec = 0;
  int   n_err = 0;

  sigma_delta_modulator_if bus ();

  sigma_delta_modulator #(.OSR(OSR), .CW(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .sdm (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b0;
    bus.IN_VALID = 1'b0;
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
  endtask

  // Present one sample for a single cycle while the hold register is empty.
  task automatic push_one(input logic [7:0] val);
    bus.IN = val;
    bus.IN_VALID = 1'b1;
    @(negedge CLK);
    bus.IN_VALID = 1'b0;
  endtask

  // Wait (bounded) for a FRAME pulse; counts IN_READY=1 cycles seen before it.
  task automatic wait_frame(output int rdy_seen);
    bit found;
    found = 1'b0;
    rdy_seen = 0;
    for (int i = 0; i < 2 * OSR + 8 && !found; i++) begin
      @(negedge CLK);
      if (bus.FRAME === 1'b1) found = 1'b1;
      else if (bus.IN_READY === 1'b1) rdy_seen++;
    end
    if (!found) check_eq("frame_timeout", 0, 1);
  endtask

  // Called in the FRAME cycle: optionally offer a sample, then observe the next
  // OSR output bits, which all come from the newly loaded cur.
  task automatic run_frame(input bit push, input logic [7:0] val,
                           output int ones, output int frames, output logic [7:0] pat);
    if (push) begin
      bus.IN = val;
      bus.IN_VALID = 1'b1;
    end
    ones = 0;
    frames = 0;
    pat = '0;
    for (int j = 0; j < OSR; j++) begin
      @(negedge CLK);
      if (j == 0) bus.IN_VALID = 1'b0;
      if (bus.OUT === 1'b1) ones++;
      if (bus.FRAME === 1'b1) frames++;
      if (j < 8) pat[j] = bus.OUT;
    end
  endtask

  initial begin
    int ones, frames, rdy;
    logic [7:0] pat;

    RST = 1'b0;
    bus.IN = '0;
    bus.IN_VALID = 1'b0;
`ifdef SDM_MUTE_EN
    bus.MUTE = 1'b0;
`endif

    // Reset state, during and one cycle after release
    repeat (4) @(negedge CLK);
    check_eq("rst_out", bus.OUT, 0);
    check_eq("rst_ready", bus.IN_READY, 1);
    check_eq("rst_frame", bus.FRAME, 0);
    check_eq("rst_underrun", bus.UNDERRUN, 0);
    RST = 1'b1;
    @(negedge CLK);
    check_eq("post_rst_out", bus.OUT, 0);
    check_eq("post_rst_ready", bus.IN_READY, 1);
    check_eq("post_rst_frame", bus.FRAME, 0);
    check_eq("post_rst_underrun", bus.UNDERRUN, 0);

    // Single sample 0x40: 64 ones, repeating 0,0,0,1
    push_one(8'h40);
    wait_frame(rdy);
    run_frame(1'b0, 8'h00, ones, frames, pat);
    check_eq("s40_ones", ones, 64);
    check_eq("s40_pattern", pat, 8'h88);
    check_eq("s40_frames", frames, 1);

    // Handshake: 0x10 then 0x20 back to back
    do_reset();
    bus.IN = 8'h10;
    bus.IN_VALID = 1'b1;
    @(negedge CLK);
    check_eq("hs_ready_drop", bus.IN_READY, 0);
    bus.IN = 8'h20;
    wait_frame(rdy);
    check_eq("hs_stall", rdy, 0);
    check_eq("hs_ready_at_frame", bus.IN_READY, 1);
    run_frame(1'b0, 8'h00, ones, frames, pat);
    check_eq("hs_ones_10", ones, 16);
    check_eq("hs_frames_1", frames, 1);
    run_frame(1'b0, 8'h00, ones, frames, pat);
    check_eq("hs_ones_20", ones, 32);
    check_eq("hs_frames_2", frames, 1);

    // Edge values 0x00 then 0xFF, no gaps
    do_reset();
    push_one(8'h00);
    wait_frame(rdy);
    run_frame(1'b1, 8'hFF, ones, frames, pat);
    check_eq("edge_ones_00", ones, 0);
    run_frame(1'b1, 8'hFF, ones, frames, pat);
    check_eq("edge_ones_ff", ones, 255);
    check_eq("edge_underrun", bus.UNDERRUN, 0);

    // Underrun: one sample then starve
    do_reset();
    push_one(8'h80);
    wait_frame(rdy);
    check_eq("ur_first_boundary", bus.UNDERRUN, 0);
    run_frame(1'b0, 8'h00, ones, frames, pat);
    check_eq("ur_ones_1", ones, 128);
    check_eq("ur_set", bus.UNDERRUN, 1);
    run_frame(1'b0, 8'h00, ones, frames, pat);
    check_eq("ur_ones_2", ones, 128);
    check_eq("ur_sticky", bus.UNDERRUN, 1);
    do_reset();
    check_eq("ur_cleared", bus.UNDERRUN, 0);

    // Loopback: boxcar decimation of a constant 0xA5 stream over one frame
    push_one(8'hA5);
    wait_frame(rdy);
    run_frame(1'b1, 8'hA5, ones, frames, pat);
    check_eq("loop_a5_in_range", (ones >= 8'hA4 && ones <= 8'hA6) ? 1 : 0, 1);
    run_frame(1'b1, 8'hA5, ones, frames, pat);
    check_eq("loop_a5_in_range_2", (ones >= 8'hA4 && ones <= 8'hA6) ? 1 : 0, 1);

`ifdef SDM_MUTE_EN
    // Mute: midscale overrides cur=0x10
    do_reset();
    push_one(8'h10);
    wait_frame(rdy);
    bus.MUTE = 1'b1;
    run_frame(1'b0, 8'h00, ones, frames, pat);
    check_eq("mute_ones", ones, 128);
    check_eq("mute_pattern", pat, 8'hAA);
    bus.MUTE = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_sigma_delta_modulator
`default_nettype wire
